// File: rtl/time_sentence_tx.sv
// rtl/time_sentence_tx.sv - UART broadcaster of "$GPTIM,hhmmss*CC\r\n" on each pps strobe
// Define TX_PARITY_EN to add an even-parity bit per character (8E1 instead of 8N1).
module time_sentence_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pps_in,
  input  logic [3:0] sec_1,
  input  logic [2:0] sec_2,
  input  logic [3:0] min_1,
  input  logic [2:0] min_2,
  input  logic [3:0] hour_1,
  input  logic [1:0] hour_2,
  output logic       tx_out,
  output logic       busy,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [4:0] LAST_CHAR = 5'd17;
  // XOR of the fixed "GPTIM," characters that precede the digits
  localparam logic [7:0] CSUM_PREFIX = 8'h47 ^ 8'h50 ^ 8'h54 ^ 8'h49 ^ 8'h4D ^ 8'h2C;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [4:0]      char_q, char_d;
  logic            tx_q, tx_d;
  logic            ovr_q, ovr_d;
  logic            latch;
  logic [1:0]      h2_q;
  logic [3:0]      h1_q, m1_q, s1_q;
  logic [2:0]      m2_q, s2_q;
  logic [7:0]      csum;
  logic [7:0]      cur_char;

  function automatic logic [7:0] enc_digit(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : {4'h3, d};
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  assign csum = CSUM_PREFIX ^ enc_digit({2'b00, h2_q}) ^ enc_digit(h1_q)
              ^ enc_digit({1'b0, m2_q}) ^ enc_digit(m1_q)
              ^ enc_digit({1'b0, s2_q}) ^ enc_digit(s1_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    char_d  = char_q;
    latch   = 1'b0;
    ovr_d   = ovr_q | (pps_in && (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (pps_in) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = 3'd0;
          char_d  = 5'd0;
          latch   = 1'b1;
        end
      end
      S_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef TX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (char_q < LAST_CHAR) begin
            char_d  = char_q + 1'b1;
            state_d = S_START;
          end else begin
            char_d  = 5'd0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Character selected by the next index so tx_out is registered in step with the state
  always_comb begin
    cur_char = 8'h0A;
    case (char_d)
      5'd0:  cur_char = 8'h24;
      5'd1:  cur_char = 8'h47;
      5'd2:  cur_char = 8'h50;
      5'd3:  cur_char = 8'h54;
      5'd4:  cur_char = 8'h49;
      5'd5:  cur_char = 8'h4D;
      5'd6:  cur_char = 8'h2C;
      5'd7:  cur_char = enc_digit({2'b00, h2_q});
      5'd8:  cur_char = enc_digit(h1_q);
      5'd9:  cur_char = enc_digit({1'b0, m2_q});
      5'd10: cur_char = enc_digit(m1_q);
      5'd11: cur_char = enc_digit({1'b0, s2_q});
      5'd12: cur_char = enc_digit(s1_q);
      5'd13: cur_char = 8'h2A;
      5'd14: cur_char = hex_char(csum[7:4]);
      5'd15: cur_char = hex_char(csum[3:0]);
      5'd16: cur_char = 8'h0D;
      default: cur_char = 8'h0A;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = cur_char[bit_d];
`ifdef TX_PARITY_EN
      S_PARITY: tx_d = ^cur_char;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      char_q  <= 5'd0;
      tx_q    <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      char_q  <= char_d;
      tx_q    <= tx_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      h2_q <= hour_2;
      h1_q <= hour_1;
      m2_q <= min_2;
      m1_q <= min_1;
      s2_q <= sec_2;
      s1_q <= sec_1;
    end
  end

  assign tx_out  = tx_q;
  assign busy    = (state_q != S_IDLE);
  assign overrun = ovr_q;

endmodule

// File: tb/tb_time_sentence_tx.sv
// tb/tb_time_sentence_tx.sv - directed bench for time_sentence_tx at 16 clks/bit
module tb_time_sentence_tx;

  localparam int CPB = 16;
`ifdef TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int LEN = 18 * FB * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pps_in = 1'b0;
  logic [3:0] sec_1, min_1, hour_1;
  logic [2:0] sec_2, min_2;
  logic [1:0] hour_2;
  logic       tx_out, busy, overrun;

  int compared = 0;
  int mismatched = 0;
  logic tx_log [0:3999];
  logic busy_log [0:3999];

  always #5 clk = ~clk;

  time_sentence_tx #(.CLK_FREQ(160), .BAUD(10)) dut (
    .clk(clk), .reset(reset), .pps_in(pps_in),
    .sec_1(sec_1), .sec_2(sec_2), .min_1(min_1), .min_2(min_2),
    .hour_1(hour_1), .hour_2(hour_2),
    .tx_out(tx_out), .busy(busy), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    compared++;
    assert (obs == exp) else begin
      mismatched++;
      $error("FAIL %s: observed %s expected %s", tag, obs, exp);
    end
  endtask

  task automatic set_time(input logic [1:0] h2, input logic [3:0] h1, input logic [2:0] m2,
                          input logic [3:0] m1, input logic [2:0] s2, input logic [3:0] s1);
    hour_2 = h2; hour_1 = h1; min_2 = m2; min_1 = m1; sec_2 = s2; sec_1 = s1;
  endtask

  // Log n cycles starting on the first cycle after the accepted strobe
  task automatic capture(input int n, input int pps_at, input int chg_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_log[i]   = tx_out;
      busy_log[i] = busy;
      pps_in = (i == pps_at);
      if (i == chg_at) set_time(2, 3, 5, 9, 5, 9);
    end
  endtask

  function automatic logic exp_level(input string s, input int i);
    int c, b;
    logic [7:0] v;
    c = i / (FB * CPB);
    if (c >= 18) return 1'b1;
    b = (i % (FB * CPB)) / CPB;
    v = s[c];
    if (b == 0) return 1'b0;
    if (b <= 8) return v[b-1];
`ifdef TX_PARITY_EN
    if (b == 9) return ^v;
`endif
    return 1'b1;
  endfunction

  task automatic check_sentence(input string tag, input string exp, input int n);
    int bad, nb;
    string got;
    logic [7:0] v;
    bad = 0;
    nb = 0;
    for (int i = 0; i < n; i++) begin
      if (tx_log[i] !== exp_level(exp, i)) bad++;
      if (busy_log[i] === 1'b1) nb++;
    end
    check({tag, "_wave_errs"}, bad, 0);
    check({tag, "_busy_clks"}, nb, (n < LEN) ? n : LEN);
    if (n >= LEN) begin
      got = "";
      for (int c = 0; c < 18; c++) begin
        for (int b = 0; b < 8; b++) v[b] = tx_log[c*FB*CPB + (b+1)*CPB + CPB/2];
        got = $sformatf("%s%c", got, v);
      end
      check_str({tag, "_text"}, got, exp);
    end
  endtask

  initial begin
    set_time(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_tx", tx_out, 1);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    @(negedge clk);

    pps_in = 1'b1;
    capture(LEN + 16, -1, -1);
    check("t2_first_tx", tx_log[0], 0);
    check("t2_first_busy", busy_log[0], 1);
    check("t2_start_run", {tx_log[47], tx_log[48]}, 2'b01);
    check_sentence("t2", "$GPTIM,000000*6B\015\012", LEN + 16);

    set_time(1, 2, 3, 4, 5, 6);
    @(negedge clk);
    pps_in = 1'b1;
    capture(LEN + 16, -1, -1);
    check_sentence("t1", "$GPTIM,123456*6C\015\012", LEN + 16);
`ifdef TX_PARITY_EN
    check("par_dollar", tx_log[152], 0);
    check("par_one", tx_log[7*FB*CPB + 152], 1);
`endif
    check("t1_overrun", overrun, 0);

    @(negedge clk);
    pps_in = 1'b1;
    capture(LEN, 1000, -1);
    check_sentence("t3a", "$GPTIM,123456*6C\015\012", LEN);
    check("t3_overrun_set", overrun, 1);
    @(negedge clk);
    check("t3_busy_fell", busy, 0);
    pps_in = 1'b1;
    capture(LEN + 16, -1, -1);
    check("t3b_first_tx", tx_log[0], 0);
    check_sentence("t3b", "$GPTIM,123456*6C\015\012", LEN + 16);
    check("t3_overrun_sticky", overrun, 1);

    @(negedge clk);
    pps_in = 1'b1;
    capture(LEN + 16, -1, 500);
    check_sentence("t4a", "$GPTIM,123456*6C\015\012", LEN + 16);
    @(negedge clk);
    pps_in = 1'b1;
    capture(LEN + 16, -1, -1);
    check_sentence("t4b", "$GPTIM,235959*6A\015\012", LEN + 16);

    set_time(1, 4'hC, 3, 4, 5, 6);
    @(negedge clk);
    pps_in = 1'b1;
    capture(LEN + 16, -1, -1);
    check_sentence("t5a", "$GPTIM,1?3456*61\015\012", LEN + 16);

    @(negedge clk);
    pps_in = 1'b1;
    capture(500, -1, -1);
    check_sentence("t5_pre_rst", "$GPTIM,1?3456*61\015\012", 500);
    check("t5_tx_low_before_rst", tx_out, 0);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_tx", tx_out, 1);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_overrun", overrun, 0);
    reset = 1'b0;
    set_time(1, 2, 3, 4, 5, 6);
    @(negedge clk);
    pps_in = 1'b1;
    capture(LEN + 16, -1, -1);
    check_sentence("t5b", "$GPTIM,123456*6C\015\012", LEN + 16);
    check("t5b_overrun", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
